sevenseg_scan_reader: RTL and testbench

- Receive-side counterpart of the team's BCD-to-7-segment decoder.
- Monitors a multiplexed 4-digit, active-low 7-segment bus (seg[6:0] plus anode select an[3:0]) and recovers the digit code per position.
- Assembles a 16-bit value once all four digits are captured and flags illegal patterns.
- Used on the board's self-check path: proves that what the display shows matches what the datapath intended.

---
 rtl/sevenseg_scan_reader.sv | 195 +++++++++++++++++++
 tb/tb_sevenseg_scan_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_reader.sv
// sevenseg_scan_reader
// Watches a multiplexed, active-low 4-digit 7-segment bus and recovers the
// digit code shown at each position. Once all four positions have been
// captured, it publishes a 16-bit value and per-digit illegal-pattern flags.
// A partial frame that does not complete within TIMEOUT cycles is discarded.

module sevenseg_scan_reader #(
    parameter int unsigned STABLE_CYC = 8,
    parameter int unsigned TIMEOUT    = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic        timeout
);

    localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    STABLE_MAX = 8'(STABLE_CYC);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    // Segment pattern to {err, code}; blank is legal and reads as F.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1000000: decode_seg = {1'b0, 4'h0};
            7'b1111001: decode_seg = {1'b0, 4'h1};
            7'b0100100: decode_seg = {1'b0, 4'h2};
            7'b0110000: decode_seg = {1'b0, 4'h3};
            7'b0011001: decode_seg = {1'b0, 4'h4};
            7'b0010010: decode_seg = {1'b0, 4'h5};
            7'b0000010: decode_seg = {1'b0, 4'h6};
            7'b1111000: decode_seg = {1'b0, 4'h7};
            7'b0000000: decode_seg = {1'b0, 4'h8};
            7'b0011000: decode_seg = {1'b0, 4'h9};
            7'b1111111: decode_seg = {1'b0, 4'hF};
            default:    decode_seg = {1'b1, 4'hE};
        endcase
    endfunction

    // True when exactly one anode is driven (low); ghosted or idle selects
    // must never be attributed to a digit.
    function automatic logic one_low(input logic [3:0] a);
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    logic [3:0]    an_s1_q, an_s2_q;
    logic [6:0]    seg_s1_q, seg_s2_q;
    logic [10:0]   prev_q;
    logic [7:0]    stab_q, stab_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    seen_q, seen_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   code_q;
    logic [3:0]    derr_q;
    logic [15:0]   value_q;
    logic [3:0]    err_q;
    logic          fv_q, to_q;

    logic [10:0]   sample;
    logic          cap_v;
    logic [3:0]    cap_bit;
    logic [4:0]    dec;
    logic          emit, tmo_fire;

    assign sample = {an_s2_q, seg_s2_q};
    assign dec    = decode_seg(seg_s2_q);

    // Stability counter: saturating run length of identical synchronized
    // samples; capture fires only on the cycle the run first reaches the limit.
    always_comb begin
        stab_d = 8'd1;
        if (sample == prev_q) begin
            stab_d = (stab_q == STABLE_MAX) ? stab_q : stab_q + 8'd1;
        end
        cap_v   = (stab_d == STABLE_MAX) && (stab_q != STABLE_MAX) && one_low(an_s2_q);
        cap_bit = cap_v ? ~an_s2_q : 4'b0000;
    end

    // Frame FSM: collect captures, emit when all four seen, discard on timeout.
    // A capture landing in the EMIT cycle directly opens the next frame.
    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        tmo_d    = tmo_q;
        emit     = 1'b0;
        tmo_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (cap_v) begin
                    seen_d  = cap_bit;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                seen_d = seen_q | cap_bit;
                tmo_d  = tmo_q + 1'b1;
                if (seen_d == 4'b1111) begin
                    // completion takes priority over a coincident timeout
                    state_d = ST_EMIT;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = ST_IDLE;
                    seen_d   = 4'b0000;
                    tmo_d    = '0;
                    tmo_fire = 1'b1;
                end
            end
            ST_EMIT: begin
                emit    = 1'b1;
                tmo_d   = '0;
                seen_d  = cap_bit;
                state_d = cap_v ? ST_COLLECT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                seen_d  = 4'b0000;
                tmo_d   = '0;
            end
        endcase
    end

    // Two-flop synchronizers and the previous-sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1_q  <= 4'b0000;
            an_s2_q  <= 4'b0000;
            seg_s1_q <= 7'b0000000;
            seg_s2_q <= 7'b0000000;
            prev_q   <= 11'b0;
            stab_q   <= 8'd0;
        end else begin
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            prev_q   <= sample;
            stab_q   <= stab_d;
        end
    end

    // Frame control state and per-digit store (store survives completion).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seen_q  <= 4'b0000;
            tmo_q   <= '0;
            code_q  <= 16'h0000;
            derr_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            tmo_q   <= tmo_d;
            for (int i = 0; i < 4; i++) begin
                if (cap_bit[i]) begin
                    code_q[4*i +: 4] <= dec[3:0];
                    derr_q[i]        <= dec[4];
                end
            end
        end
    end

    // Published result and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 16'h0000;
            err_q   <= 4'b0000;
            fv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            if (emit) begin
                value_q <= code_q;
                err_q   <= derr_q;
            end
            fv_q <= emit;
            to_q <= tmo_fire;
        end
    end

    assign value       = value_q;
    assign err         = err_q;
    assign frame_valid = fv_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Bench for sevenseg_scan_reader: directed scenarios with literal expected
// values plus a randomized run scored against a run-length/frame model.

module tb_sevenseg_scan_reader;

    localparam int S = 8;
    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_i = 7'h7F;
    logic [3:0]  an_i = 4'hF;
    logic [15:0] value;
    logic [3:0]  err;
    logic        frame_valid;
    logic        timeout;

    sevenseg_scan_reader #(.STABLE_CYC(S), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg_i), .an(an_i),
        .value(value), .err(err), .frame_valid(frame_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [6:0] P [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    // Observed results
    logic [19:0] got_q[$];
    int          got_tmo_cyc[$];
    always @(negedge clk) begin
        if (frame_valid === 1'b1) got_q.push_back({err, value});
        if (timeout === 1'b1) got_tmo_cyc.push_back(cyc);
    end

    // Reference model: runs of identical samples, capture after S samples,
    // frames assembled in a per-position store, timeout T edges after first capture.
    logic [10:0] m_prev = {4'hF, 7'h7F};
    int          m_start = 0, m_len = 0;
    logic [3:0]  m_seen = 4'h0;
    logic [15:0] m_code = 16'h0;
    logic [3:0]  m_err = 4'h0;
    int          m_first = 0;
    int          exp_tmo = 0;
    logic [19:0] exp_q[$];
    int          last_start = 0;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int k = 0; k < 10; k++) if (s == P[k]) return {1'b0, 4'(k)};
        if (s == 7'h7F) return {1'b0, 4'hF};
        return {1'b1, 4'hE};
    endfunction

    task automatic model_capture(input int c, input int d, input logic [4:0] de);
        logic [3:0] bitm;
        bitm = 4'b0001 << d;
        if (m_seen != 0 && c >= m_first + T) begin
            if (!(c == m_first + T && (m_seen | bitm) == 4'hF)) begin
                exp_tmo++;
                m_seen = 4'h0;
                if (c == m_first + T) return;
            end
        end
        if (m_seen == 0) m_first = c;
        m_seen = m_seen | bitm;
        m_code[4*d +: 4] = de[3:0];
        m_err[d] = de[4];
        if (m_seen == 4'hF) begin
            exp_q.push_back({m_err, m_code});
            m_seen = 4'h0;
        end
    endtask

    task automatic model_seg(input logic [3:0] a, input logic [6:0] s, input int t, input int n);
        int old;
        int d;
        if ({a, s} == m_prev) begin
            old = m_len;
            m_len = m_len + n;
        end else begin
            m_prev = {a, s};
            m_start = t;
            old = 0;
            m_len = n;
        end
        if (old < S && m_len >= S && $countones(~a) == 1) begin
            d = 0;
            for (int k = 0; k < 4; k++) if (!a[k]) d = k;
            model_capture(m_start + S + 2, d, ref_decode(s));
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        @(posedge clk);
        #1;
        an_i = a;
        seg_i = s;
        last_start = cyc;
        model_seg(a, s, cyc, n);
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        drive(4'hF, 7'h7F, n);
    endtask

    task automatic scan4(input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3, input int n);
        drive(4'b1110, d0, n);
        drive(4'b1101, d1, n);
        drive(4'b1011, d2, n);
        drive(4'b0111, d3, n);
    endtask

    task automatic start_test();
        exp_q.delete();
        got_q.delete();
        got_tmo_cyc.delete();
        exp_tmo = 0;
    endtask

    task automatic finish_test();
        idle(T + 20);
        if (m_seen != 0) begin
            exp_tmo++;
            m_seen = 4'h0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (value !== 16'h0) begin fails++; $display("FAIL reset_value: got %h want 0000", value); end
        tests++; if (err !== 4'h0) begin fails++; $display("FAIL reset_err: got %b want 0000", err); end
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_2049();
        start_test();
        scan4(P[9], P[4], P[0], P[2], 20);
        finish_test();
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL 2049_frames: got %0d want 1", got_q.size()); end
        else begin
            tests++; if (got_q[0] !== {4'b0000, 16'h2049}) begin fails++; $display("FAIL 2049_value: got %h want 02049", got_q[0]); end
        end
        tests++; if (got_tmo_cyc.size() != 0) begin fails++; $display("FAIL 2049_timeouts: got %0d want 0", got_tmo_cyc.size()); end
    endtask

    task automatic test_glitch();
        start_test();
        drive(4'b1110, P[5], S - 1);
        drive(4'b1101, P[1], 12);
        drive(4'b1011, P[1], 12);
        drive(4'b0111, P[1], 12);
        finish_test();
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL glitch7_frames: got %0d want 0", got_q.size()); end
        tests++; if (got_tmo_cyc.size() != 1) begin fails++; $display("FAIL glitch7_timeouts: got %0d want 1", got_tmo_cyc.size()); end
        start_test();
        drive(4'b1110, P[5], S);
        drive(4'b1101, P[1], 12);
        drive(4'b1011, P[1], 12);
        drive(4'b0111, P[1], 12);
        finish_test();
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL glitch8_frames: got %0d want 1", got_q.size()); end
        else begin
            tests++; if (got_q[0] !== {4'b0000, 16'h1115}) begin fails++; $display("FAIL glitch8_value: got %h want 01115", got_q[0]); end
        end
    endtask

    task automatic test_illegal_blank();
        start_test();
        scan4(P[1], 7'b0101010, 7'b1111111, P[1], 15);
        finish_test();
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL illegal_frames: got %0d want 1", got_q.size()); end
        else begin
            tests++; if (got_q[0][15:0] !== 16'h1FE1) begin fails++; $display("FAIL illegal_value: got %h want 1FE1", got_q[0][15:0]); end
            tests++; if (got_q[0][19:16] !== 4'b0010) begin fails++; $display("FAIL illegal_err: got %b want 0010", got_q[0][19:16]); end
        end
    endtask

    task automatic test_ghost();
        start_test();
        drive(4'b1100, P[8], 50);
        finish_test();
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL ghost_frames: got %0d want 0", got_q.size()); end
        tests++; if (got_tmo_cyc.size() != 0) begin fails++; $display("FAIL ghost_timeouts: got %0d want 0", got_tmo_cyc.size()); end
        start_test();
        scan4(P[3], P[7], P[6], P[8], 16);
        finish_test();
        tests++; if (got_q.size() != 1 || got_q[0] !== {4'b0000, 16'h8673}) begin
            fails++; $display("FAIL ghost_recover: frames %0d first %h want 1 frame 08673", got_q.size(), got_q.size() > 0 ? got_q[0] : 20'h0);
        end
    endtask

    task automatic test_timeout();
        int t0;
        start_test();
        drive(4'b1110, P[1], 20);
        t0 = last_start;
        drive(4'b1101, P[2], 20);
        drive(4'b1011, P[3], 20);
        idle(T + 40);
        tests++; if (got_tmo_cyc.size() != 1) begin fails++; $display("FAIL timeout_count: got %0d want 1", got_tmo_cyc.size()); end
        else begin
            tests++; if (got_tmo_cyc[0] != t0 + S + 2 + T) begin fails++; $display("FAIL timeout_cycle: got %0d want %0d", got_tmo_cyc[0], t0 + S + 2 + T); end
        end
        tests++; if (value !== 16'h8673 || got_q.size() != 0) begin fails++; $display("FAIL timeout_value_kept: got %h frames %0d want 8673 frames 0", value, got_q.size()); end
        scan4(P[4], P[5], P[6], P[7], 12);
        finish_test();
        tests++; if (got_q.size() != 1 || value !== 16'h7654) begin fails++; $display("FAIL timeout_recover: got %h frames %0d want 7654 frames 1", value, got_q.size()); end
    endtask

    task automatic test_back_to_back();
        start_test();
        scan4(P[1], P[2], P[3], P[4], 10);
        scan4(P[5], P[6], P[7], P[8], 10);
        finish_test();
        tests++; if (got_q.size() != 2) begin fails++; $display("FAIL b2b_frames: got %0d want 2", got_q.size()); end
        else begin
            tests++; if (got_q[0] !== {4'b0000, 16'h4321}) begin fails++; $display("FAIL b2b_first: got %h want 04321", got_q[0]); end
            tests++; if (got_q[1] !== {4'b0000, 16'h8765}) begin fails++; $display("FAIL b2b_second: got %h want 08765", got_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        start_test();
        scan4(P[4], P[3], P[2], P[1], 12);
        drive(4'b1110, P[5], 12);
        drive(4'b1101, P[5], 12);
        drive(4'b1011, P[5], 12);
        @(posedge clk);
        #1;
        an_i = 4'hF;
        seg_i = 7'h7F;
        rst_n = 1'b0;
        #1;
        tests++; if (value !== 16'h0 || err !== 4'h0 || frame_valid !== 1'b0 || timeout !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs: value %h err %b fv %b to %b want all zero", value, err, frame_valid, timeout);
        end
        m_seen = 4'h0;
        m_prev = {4'hF, 7'h7F};
        m_len = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);
        drive(4'b0111, P[9], 12);
        finish_test();
        tests++; if (got_q.size() != 1 || got_q[0] !== {4'b0000, 16'h1234}) begin
            fails++; $display("FAIL midreset_frames: frames %0d want only pre-reset 01234", got_q.size());
        end
        tests++; if (value !== 16'h0) begin fails++; $display("FAIL midreset_no_frame: got %h want 0000", value); end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        int r;
        start_test();
        for (int b = 0; b < 30; b++) begin
            for (int k = 0; k < $urandom_range(3, 7); k++) begin
                if ($urandom_range(0, 7) == 0) a = 4'($urandom_range(0, 15));
                else a = ~(4'b0001 << $urandom_range(0, 3));
                r = $urandom_range(0, 11);
                if (r < 10) s = P[r];
                else if (r == 10) s = 7'h7F;
                else s = 7'($urandom_range(0, 127));
                drive(a, s, $urandom_range(3, 24));
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 130));
        end
        finish_test();
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_frames: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_frame%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (got_tmo_cyc.size() != exp_tmo) begin fails++; $display("FAIL rand_timeouts: got %0d want %0d", got_tmo_cyc.size(), exp_tmo); end
    endtask

    initial begin
        test_reset();
        test_2049();
        test_glitch();
        test_illegal_blank();
        test_ghost();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
